// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Opcodes, control-field encodings and FSM state codes shared by
//            the multi-cycle MIPS control path.
// Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ)  || (op == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Purpose  : Multi-cycle MIPS sequencer: fetch/decode/execute/memory/write-back
//            with memory-ready stalls, driving the datapath mux and enables.
// Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm
  import mips_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op_q;

  logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
  logic       w_irwrite, w_memtoreg, w_regdst, w_regwrite, w_alusrca;
  logic [1:0] w_alusrcb, w_aluop, w_pcsource;
  logic       w_done, w_illegal;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_FETCH;
      r_op_q  <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op_q <= Op_i;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op_i)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = SRCB_B;
    w_aluop       = ALUOP_ADD;
    w_pcsource    = PCSRC_ALU;
    w_done        = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = SRCB_FOUR;
        w_irwrite = mem_ready_i;
        w_pcwrite = mem_ready_i;
      end
      S_DECODE: begin
        w_alusrcb = SRCB_IMM_SH2;
        w_illegal = !is_supported(Op_i);
        w_done    = !is_supported(Op_i);
      end
      S_MEMADR, S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
        w_done     = mem_ready_i;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = ALUOP_SUB;
        w_pcwritecond = 1'b1;
        w_pcsource    = PCSRC_ALUOUT;
        w_done        = 1'b1;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = PCSRC_JUMP;
        w_done     = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every output combinationally so no enable leaks while rst_i is low.
  assign PCWrite_o     = w_pcwrite     & rst_i;
  assign PCWriteCond_o = w_pcwritecond & rst_i;
  assign IorD_o        = w_iord        & rst_i;
  assign MemRead_o     = w_memread     & rst_i;
  assign MemWrite_o    = w_memwrite    & rst_i;
  assign IRWrite_o     = w_irwrite     & rst_i;
  assign MemtoReg_o    = w_memtoreg    & rst_i;
  assign RegDst_o      = w_regdst      & rst_i;
  assign RegWrite_o    = w_regwrite    & rst_i;
  assign ALUSrcA_o     = w_alusrca     & rst_i;
  assign ALUSrcB_o     = w_alusrcb     & {2{rst_i}};
  assign ALUOp_o       = w_aluop       & {2{rst_i}};
  assign PCSource_o    = w_pcsource    & {2{rst_i}};
  assign instr_done_o  = w_done        & rst_i;
  assign illegal_o     = w_illegal     & rst_i;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mc_control_fsm
// Purpose  : Self-checking bench; a per-instruction cycle-list model predicts
//            every control output for randomized instruction streams.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [5:0] Op_i;
  logic       mem_ready_i;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
  logic       instr_done_o, illegal_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        ready;
    logic [5:0]  op;
    logic [18:0] exp;
  } cyc_t;
  cyc_t q[$];

  mc_control_fsm dut (
    .clk_i(clk), .rst_i(rst_i), .Op_i(Op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSource_o(PCSource_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  wire [18:0] w_obs = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o,
                       IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o,
                       ALUSrcB_o, ALUOp_o, PCSource_o, instr_done_o, illegal_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] v(input logic pcw, pcwc, iord, mr, mw, irw, m2r,
                                    rdst, rw, srca, input logic [1:0] srcb, aluop,
                                    pcsrc, input logic done, ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, done, ill};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  endfunction

  function automatic cyc_t mk(input logic ready, input logic [5:0] op, input logic [18:0] exp);
    cyc_t c;
    c.ready = ready; c.op = op; c.exp = exp;
    return c;
  endfunction

  // Expected cycle sequence of one instruction; Op_i carries junk outside DECODE.
  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++)
      q.push_back(mk(1'b0, 6'($urandom), v(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0)));
    q.push_back(mk(1'b1, 6'($urandom), v(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0)));
    if (!legal(op)) begin
      q.push_back(mk(1'($urandom), op, v(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,1)));
      return;
    end
    q.push_back(mk(1'($urandom), op, v(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0)));
    case (op)
      6'b000000: begin
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0)));
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0)));
      end
      6'b001000: begin
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0)));
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0)));
      end
      6'b100011: begin
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0)));
        for (int i = 0; i < mw; i++)
          q.push_back(mk(1'b0, 6'($urandom), v(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0)));
        q.push_back(mk(1'b1, 6'($urandom), v(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0)));
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0)));
      end
      6'b101011: begin
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0)));
        for (int i = 0; i < mw; i++)
          q.push_back(mk(1'b0, 6'($urandom), v(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0)));
        q.push_back(mk(1'b1, 6'($urandom), v(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0)));
      end
      6'b000100:
        q.push_back(mk(1'($urandom), 6'($urandom), v(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0)));
      default:
        q.push_back(mk(1'($urandom), 6'($urandom), v(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0)));
    endcase
  endtask

  // Called at a falling edge; drives, checks 1ns later, returns at a falling edge.
  task automatic run(input string tag, input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      mem_ready_i = c.ready;
      Op_i        = c.op;
      #1;
      chk($sformatf("%s_c%0d", tag, i), 32'(w_obs), 32'(c.exp));
      @(negedge clk);
    end
  endtask

  logic [5:0] ops [6] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};

  initial begin
    logic [5:0] op;
    rst_i = 1'b0; mem_ready_i = 1'b1; Op_i = 6'b100011;
    @(negedge clk); @(negedge clk);
    #1 chk("reset_outputs", 32'(w_obs), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    add_instr(6'b000000, 0, 0);   run("rtype", q.size());
    add_instr(6'b100011, 2, 3);   run("lw_stall", q.size());
    add_instr(6'b000100, 0, 0);   run("beq", q.size());
    add_instr(6'b000010, 0, 0);   run("jump", q.size());
    add_instr(6'b111111, 0, 0);   run("illegal", q.size());
    add_instr(6'b001000, 1, 0);   run("addi", q.size());
    add_instr(6'b101011, 0, 2);   run("sw", q.size());

    // Abort during the MEMWR stall: FETCH, DECODE, MEMADR, then two stall cycles.
    add_instr(6'b101011, 0, 5);
    run("sw_abort", 5);
    q.delete();
    rst_i = 1'b0;
    #1 chk("abort_same_cycle", 32'(w_obs), 32'd0);
    @(negedge clk);
    #1 chk("abort_held", 32'(w_obs), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    add_instr(6'b000000, 0, 0);   run("restart", q.size());

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run($sformatf("rnd%0d", k), q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle sequencing controller for the MIPS datapath. Replaces single-cycle opcode decode with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared ALU, register file, single unified memory port and PC mux, and stalls on a memory-ready handshake. It sits between the instruction register's opcode field and the datapath mux/enable inputs.

## Interface
- Parameters: none. Opcodes and state codes live in the shared package.
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- Op_i  in  6  opcode field of the instruction register, valid from DECODE onward
- mem_ready_i  in  1  memory completes the current read/write this cycle
- PCWrite_o  out  1  unconditional PC load
- PCWriteCond_o  out  1  PC load if ALU zero (branch)
- IorD_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead_o  out  1  memory read request
- MemWrite_o  out  1  memory write request
- IRWrite_o  out  1  instruction register load
- MemtoReg_o  out  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst_o  out  1  destination register: 0 = rt, 1 = rd
- RegWrite_o  out  1  register file write
- ALUSrcA_o  out  1  0 = PC, 1 = register A
- ALUSrcB_o  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp_o  out  2  00 = add, 01 = sub, 10 = use funct
- PCSource_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_o  out  1  one-cycle pulse in DECODE for an unsupported opcode

## Operation
- Supported opcodes:
  - R-type 000000
  - addi 001000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
- States and outputs. Any output not listed is 0.
  - FETCH: MemRead=1, IorD=0, SrcA=0, SrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite = mem_ready_i. Stay in FETCH until ready, then go to DECODE.
  - DECODE: SrcA=0, SrcB=11, ALUOp=00 (computes the branch target). Latch Op_i into op_q.
    - lw/sw → MEMADR
    - R → EXEC
    - addi → ADDIEX
    - beq → BRANCH
    - j → JUMP
    - anything else → FETCH with illegal_o=1 and instr_done_o=1
  - MEMADR: SrcA=1, SrcB=10, ALUOp=00. Next state is MEMRD if op_q is lw, otherwise MEMWR.
  - MEMRD: MemRead=1, IorD=1. Hold until mem_ready_i, then go to MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done. Next state FETCH.
  - MEMWR: MemWrite=1, IorD=1. Hold until mem_ready_i. On the ready cycle instr_done=1, then go to FETCH.
  - EXEC: SrcA=1, SrcB=00, ALUOp=10. Next state ALUWB.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done. Next state FETCH.
  - ADDIEX: SrcA=1, SrcB=10, ALUOp=00. Next state ADDIWB.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done. Next state FETCH.
  - BRANCH: SrcA=1, SrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done. Next state FETCH.
  - JUMP: PCWrite=1, PCSource=10, instr_done. Next state FETCH.
- Decode paths after DECODE use only op_q. Op_i changing after DECODE has no effect.
- MemRead and MemWrite stay asserted, with stable IorD, for every stall cycle.

## Timing
- Reset (rst_i low): state = FETCH and op_q = 0, applied asynchronously. While rst_i is low, every output is forced to 0.
- Fetch starts on the first rising edge after rst_i deasserts.
- All outputs are Moore-decoded from state, except:
  - IRWrite and PCWrite in FETCH (gated by mem_ready_i);
  - instr_done in MEMWR (gated by mem_ready_i);
  - instr_done and illegal in DECODE (gated by opcode).
- Cycles per instruction with zero-wait memory (mem_ready_i tied 1):
  - beq 3, j 3
  - R-type 4, addi 4, sw 4
  - lw 5
  - Each memory wait cycle adds 1.
- Reset asserted mid-instruction aborts immediately. No write enable may be high while rst_i is low.
- Exactly one instr_done pulse per instruction, including illegal ones.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J);
  - ALUOp encodings;
  - ALUSrcB and PCSource encodings;
  - state enum (4-bit).
- One module, no sub-modules: a state register, a next-state block and an output decode block.

## Test plan
- Reset, then rst_i high with mem_ready_i=1 → first cycle in FETCH: MemRead=1, IRWrite=1, PCWrite=1, SrcB=01.
- R-type (Op_i=000000) with zero-wait memory → 4 cycles. RegWrite=1 and RegDst=1 on cycle 4, together with instr_done. ALUOp=10 on cycle 3.
- lw with mem_ready_i low for 2 cycles in FETCH and 3 cycles in MEMRD → 10 cycles total. MemRead and IorD stay stable while stalled. MemtoReg=1 on the last cycle.
- beq → cycle 3 has PCWriteCond=1, PCSource=01, ALUOp=01. j → cycle 3 has PCWrite=1, PCSource=10. Both pulse instr_done.
- Op_i=111111 → illegal_o and instr_done pulse in DECODE; the next cycle is FETCH.
- Assert rst_i low during the MEMWR stall → all outputs go to 0 in the same cycle. After release, the FSM restarts in FETCH.
